riscv_cpu_div: RTL and testbench

Multi-cycle iterative integer divider for the RV32M/RV64M DIV, DIVU, REM and REMU operations, parametrised in operand width. It sits beside the ALU in the execute stage. The ALU issues `alu_opcode_e` division ops to it over a valid/ready handshake and stalls until the result returns. It uses a radix-2 restoring algorithm, processes one quotient bit per cycle, and returns RISC-V-compliant results for divide-by-zero and signed overflow.

---
 rtl/riscv_cpu_div_pkg.sv | 36 +++
 rtl/riscv_cpu_div_if.sv | 26 ++
 rtl/riscv_cpu_div.sv | 174 +++++++++++++++++
 tb/tb_riscv_cpu_div.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_div_pkg.sv
// Shared ALU/divider types: opcode encoding, divider FSM states and op-bit positions.
package riscv_cpu_div_pkg;

  localparam int ALU_OP_WIDTH = 5;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 5'h00,
    ALU_SUB  = 5'h01,
    ALU_AND  = 5'h02,
    ALU_OR   = 5'h03,
    ALU_XOR  = 5'h04,
    ALU_SLL  = 5'h05,
    ALU_SRL  = 5'h06,
    ALU_SRA  = 5'h07,
    ALU_SLT  = 5'h08,
    ALU_SLTU = 5'h09,
    ALU_MUL  = 5'h0C,
    // Division ops keep bit0 = signed, bit1 = remainder so the divider decodes only [1:0]
    ALU_DIVU = 5'h10,
    ALU_DIV  = 5'h11,
    ALU_REMU = 5'h12,
    ALU_REM  = 5'h13
  } alu_opcode_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  localparam int DIV_OP_SIGNED_BIT = 0;
  localparam int DIV_OP_REM_BIT    = 1;

endpackage

// File: rtl/riscv_cpu_div_if.sv
// Request/response handshake between the ALU (master) and the iterative divider (slave).
interface riscv_cpu_div_if #(
  parameter int WIDTH = 32
);
  import riscv_cpu_div_pkg::*;

  alu_opcode_e      op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] result_o;
  logic             valid_o;
  logic             ready_i;

  modport master (
    output op_i, a_i, b_i, valid_i, ready_i,
    input  ready_o, result_o, valid_o
  );

  modport slave (
    input  op_i, a_i, b_i, valid_i, ready_i,
    output ready_o, result_o, valid_o
  );

endinterface

// File: rtl/riscv_cpu_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define RISCV_CPU_DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow straight from PREP.
module riscv_cpu_div
  import riscv_cpu_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  riscv_cpu_div_if.slave div_bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             ready_r;
  logic             valid_r;
  logic [WIDTH-1:0] result_r;

  logic             signed_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_abs_s;
  logic [WIDTH-1:0] b_abs_s;
  logic             div_zero_s;
  logic             ovf_s;
  logic [WIDTH+1:0] shift_s;
  logic [WIDTH+1:0] diff_s;
  logic             borrow_s;
  logic [WIDTH-1:0] quo_final_s;
  logic [WIDTH-1:0] rem_final_s;
  logic [WIDTH-1:0] res_sel_s;

  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
    if (en) begin
      return ~v + WIDTH'(1'b1);
    end else begin
      return v;
    end
  endfunction

  // Operand conditioning, trial subtraction and final result selection.
  always_comb begin
    signed_s    = op_r[DIV_OP_SIGNED_BIT];
    a_neg_s     = signed_s & a_r[WIDTH-1];
    b_neg_s     = signed_s & b_r[WIDTH-1];
    a_abs_s     = neg_if(a_neg_s, a_r);
    b_abs_s     = neg_if(b_neg_s, b_r);
    div_zero_s  = (b_r == {WIDTH{1'b0}});
    ovf_s       = signed_s && (a_r == MOST_NEG) && (b_r == {WIDTH{1'b1}});
    // rem_r < divisor, so a negative difference always sets the top bit
    shift_s     = {rem_r, quo_r[WIDTH-1]};
    diff_s      = shift_s - {2'b00, dvsr_r};
    borrow_s    = diff_s[WIDTH+1];
    quo_final_s = neg_if(q_neg_r, quo_r);
    rem_final_s = neg_if(r_neg_r, rem_r[WIDTH-1:0]);
    if (div_zero_s) begin
      quo_final_s = {WIDTH{1'b1}};
      rem_final_s = a_r;
    end else if (ovf_s) begin
      quo_final_s = a_r;
      rem_final_s = {WIDTH{1'b0}};
    end else begin
      quo_final_s = quo_final_s;
      rem_final_s = rem_final_s;
    end
    if (op_r[DIV_OP_REM_BIT]) begin
      res_sel_s = rem_final_s;
    end else begin
      res_sel_s = quo_final_s;
    end
  end

  // Divider control FSM with registered handshake outputs and result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      op_r     <= 2'b00;
      a_r      <= '0;
      b_r      <= '0;
      quo_r    <= '0;
      rem_r    <= '0;
      dvsr_r   <= '0;
      cnt_r    <= '0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      result_r <= '0;
    end else if (flush_i) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ready_r <= 1'b1;
          if (div_bus.valid_i && ready_r) begin
            op_r    <= div_bus.op_i[1:0];
            a_r     <= div_bus.a_i;
            b_r     <= div_bus.b_i;
            ready_r <= 1'b0;
            state_r <= PREP;
          end
        end
        PREP: begin
          quo_r   <= a_abs_s;
          dvsr_r  <= b_abs_s;
          rem_r   <= '0;
          cnt_r   <= CNT_W'(WIDTH);
          q_neg_r <= a_neg_s ^ b_neg_s;
          r_neg_r <= a_neg_s;
`ifdef RISCV_CPU_DIV_EARLY_OUT_EN
          if (div_zero_s || ovf_s) begin
            result_r <= res_sel_s;
            valid_r  <= 1'b1;
            state_r  <= DONE;
          end else begin
            state_r <= DIV;
          end
`else
          state_r <= DIV;
`endif
        end
        DIV: begin
          if (!borrow_s) begin
            rem_r <= diff_s[WIDTH:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= shift_s[WIDTH:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r - CNT_W'(1'b1);
          if (cnt_r == CNT_W'(1'b1)) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          result_r <= res_sel_s;
          valid_r  <= 1'b1;
          state_r  <= DONE;
        end
        DONE: begin
          if (div_bus.ready_i) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign div_bus.ready_o  = ready_r;
  assign div_bus.valid_o  = valid_r;
  assign div_bus.result_o = result_r;

endmodule

// File: tb/tb_riscv_cpu_div.sv
// Directed self-checking bench for riscv_cpu_div at WIDTH=32 and WIDTH=8.
module tb_riscv_cpu_div;
  import riscv_cpu_div_pkg::*;

`ifdef RISCV_CPU_DIV_EARLY_OUT_EN
  localparam int LAT_SP32 = 2;
  localparam int LAT_SP8  = 2;
`else
  localparam int LAT_SP32 = 35;
  localparam int LAT_SP8  = 11;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush32;
  logic flush8;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  riscv_cpu_div_if #(.WIDTH(32)) bus32 ();
  riscv_cpu_div_if #(.WIDTH(8))  bus8 ();

  riscv_cpu_div #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .flush_i(flush32), .div_bus(bus32.slave));
  riscv_cpu_div #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .flush_i(flush8),  .div_bus(bus8.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start32(input alu_opcode_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus32.op_i    = op;
    bus32.a_i     = a;
    bus32.b_i     = b;
    bus32.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus32.valid_i = 1'b0;
  endtask

  task automatic wait32(output int lat);
    int e = 0;
    while (!bus32.valid_o && e < 100) begin
      @(posedge clk);
      #1;
      e++;
    end
    lat = e + 1;
  endtask

  task automatic ack32;
    bus32.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus32.ready_i = 1'b0;
  endtask

  task automatic op32(input string tag, input alu_opcode_e op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    start32(op, a, b);
    wait32(lat);
    check({tag, " result"}, bus32.result_o, exp);
    check({tag, " latency"}, lat, exp_lat);
    ack32();
  endtask

  task automatic op8(input string tag, input alu_opcode_e op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
    int e = 0;
    @(negedge clk);
    bus8.op_i    = op;
    bus8.a_i     = a;
    bus8.b_i     = b;
    bus8.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus8.valid_i = 1'b0;
    while (!bus8.valid_o && e < 100) begin
      @(posedge clk);
      #1;
      e++;
    end
    check({tag, " result"}, bus8.result_o, exp);
    check({tag, " latency"}, e + 1, exp_lat);
    bus8.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus8.ready_i = 1'b0;
  endtask

  initial begin
    int lat;
    rst     = 1'b1;
    flush32 = 1'b0;
    flush8  = 1'b0;
    bus32.op_i = ALU_DIVU; bus32.a_i = 32'h0; bus32.b_i = 32'h0;
    bus32.valid_i = 1'b0;  bus32.ready_i = 1'b0;
    bus8.op_i = ALU_DIVU;  bus8.a_i = 8'h0;   bus8.b_i = 8'h0;
    bus8.valid_i = 1'b0;   bus8.ready_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset ready", bus32.ready_o, 1'b1);
    check("reset valid", bus32.valid_o, 1'b0);
    check("reset result", bus32.result_o, 32'h0);
    check("reset8 ready", bus8.ready_o, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    op32("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 35);
    check("post-ack ready", bus32.ready_o, 1'b1);
    check("post-ack valid", bus32.valid_o, 1'b0);
    op32("remu 100/7", ALU_REMU, 32'd100, 32'd7, 32'd2, 35);
    op32("div -7/2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    op32("rem -7/2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    op32("div 7/-2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
    op32("rem 7/-2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 35);

    op32("divu 5/0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SP32);
    op32("rem 5/0", ALU_REM, 32'd5, 32'd0, 32'd5, LAT_SP32);
    op32("remu 5/0", ALU_REMU, 32'd5, 32'd0, 32'd5, LAT_SP32);
    op32("div -5/0", ALU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LAT_SP32);
    op32("rem -5/0", ALU_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SP32);
    op32("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP32);
    op32("rem ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_SP32);
    op32("divu minneg/allones", ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 35);

    // Backpressure: result and valid must hold while ready_i is low
    start32(ALU_DIVU, 32'd100, 32'd7);
    wait32(lat);
    check("bp latency", lat, 35);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp result", bus32.result_o, 32'd14);
      check("bp valid", bus32.valid_o, 1'b1);
      check("bp ready", bus32.ready_o, 1'b0);
    end
    ack32();

    // Flush beats a same-cycle request
    @(negedge clk);
    bus32.op_i = ALU_DIVU; bus32.a_i = 32'd8; bus32.b_i = 32'd2;
    bus32.valid_i = 1'b1;
    flush32 = 1'b1;
    @(posedge clk);
    #1;
    bus32.valid_i = 1'b0;
    flush32 = 1'b0;
    check("flush prio ready", bus32.ready_o, 1'b1);
    check("flush prio valid", bus32.valid_o, 1'b0);

    // Flush during DIV cycle 5
    start32(ALU_DIVU, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    flush32 = 1'b1;
    @(posedge clk);
    #1;
    flush32 = 1'b0;
    check("flush ready", bus32.ready_o, 1'b1);
    check("flush valid", bus32.valid_o, 1'b0);
    check("flush result hold", bus32.result_o, 32'd14);
    op32("divu 9/3", ALU_DIVU, 32'd9, 32'd3, 32'd3, 35);

    // Reset during DIV
    start32(ALU_DIVU, 32'd50, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst-mid ready", bus32.ready_o, 1'b1);
    check("rst-mid valid", bus32.valid_o, 1'b0);
    check("rst-mid result", bus32.result_o, 32'h0);

    op8("w8 divu 255/16", ALU_DIVU, 8'd255, 8'd16, 8'd15, 11);
    op8("w8 remu 255/16", ALU_REMU, 8'd255, 8'd16, 8'd15, 11);
    op8("w8 div ovf", ALU_DIV, 8'h80, 8'hFF, 8'h80, LAT_SP8);
    op8("w8 divu 16/0", ALU_DIVU, 8'h10, 8'h00, 8'hFF, LAT_SP8);
    op8("w8 div -100/7", ALU_DIV, 8'h9C, 8'd7, 8'hF2, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
